// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types, op codes and decode helpers for the multiply/divide unit
package muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 RV64M multiply/divide unit with pipeline stall request
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              enable,
    input  logic              start,
    input  logic              flush,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic              stall_req,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        op_q;
    logic              neg_a_q, neg_b_q;
    logic [DATA_W-1:0] m_q, hi_q, lo_q, result_q;

    logic              neg_a, neg_b;
    logic [DATA_W-1:0] a_abs, b_abs;
    logic              b_zero, div_ovf, special;
    logic [DATA_W-1:0] special_res;

    logic [DATA_W:0]   add_a, add_b;
    logic              add_cin;
    logic [DATA_W+1:0] add_sum;
    logic [DATA_W-1:0] fix_sel;
    logic              fix_neg;

    always_comb begin
        neg_a   = is_signed_a(op) & operand_a[DATA_W-1];
        neg_b   = is_signed_b(op) & operand_b[DATA_W-1];
        a_abs   = neg_a ? -operand_a : operand_a;
        b_abs   = neg_b ? -operand_b : operand_b;
        b_zero  = (operand_b == '0);
        div_ovf = is_div(op) & ~op[0] & (operand_a == MIN_VAL) & (operand_b == '1);
        special = is_div(op) & (b_zero | div_ovf);
        // Overflow leaves the dividend as quotient and zero as remainder
        if (b_zero) begin
            special_res = is_rem(op) ? operand_a : '1;
        end else begin
            special_res = is_rem(op) ? '0 : operand_a;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = special ? ST_DONE : ST_CALC;
            ST_CALC: if (cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    // One adder: add during multiply, subtract (a + ~b + 1) during divide, increment for negation in FIX
    always_comb begin
        fix_sel = '0;
        fix_neg = 1'b0;
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state_q == ST_CALC) begin
            if (is_div(op_q)) begin
                add_a   = {hi_q, lo_q[DATA_W-1]};
                add_b   = ~{1'b0, m_q};
                add_cin = 1'b1;
            end else begin
                add_a = {1'b0, hi_q};
                add_b = lo_q[0] ? {1'b0, m_q} : '0;
            end
        end else if (state_q == ST_FIX) begin
            if (is_div(op_q)) begin
                fix_sel = is_rem(op_q) ? hi_q : lo_q;
                fix_neg = is_rem(op_q) ? neg_a_q : (neg_a_q ^ neg_b_q);
                add_cin = fix_neg;
            end else begin
                fix_sel = (op_q == OP_MUL) ? lo_q : hi_q;
                fix_neg = neg_a_q ^ neg_b_q;
                // Carry into the high half of a 2W negation only when the low half is zero
                add_cin = fix_neg & ((op_q == OP_MUL) | (lo_q == '0));
            end
            add_a = {1'b0, fix_neg ? ~fix_sel : fix_sel};
        end
        add_sum = {1'b0, add_a} + {1'b0, add_b} + {{(DATA_W+1){1'b0}}, add_cin};
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            m_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else if (enable) begin
            state_q <= state_d;
            if (!flush) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            if (special) begin
                                result_q <= special_res;
                            end else begin
                                op_q    <= op;
                                neg_a_q <= neg_a;
                                neg_b_q <= neg_b;
                                m_q     <= is_div(op) ? b_abs : a_abs;
                                lo_q    <= is_div(op) ? a_abs : b_abs;
                                hi_q    <= '0;
                                cnt_q   <= '0;
                            end
                        end
                    end
                    ST_CALC: begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (is_div(op_q)) begin
                            if (add_sum[DATA_W+1]) begin
                                hi_q <= add_sum[DATA_W-1:0];
                                lo_q <= {lo_q[DATA_W-2:0], 1'b1};
                            end else begin
                                hi_q <= {hi_q[DATA_W-2:0], lo_q[DATA_W-1]};
                                lo_q <= {lo_q[DATA_W-2:0], 1'b0};
                            end
                        end else begin
                            hi_q <= add_sum[DATA_W:1];
                            lo_q <= {add_sum[0], lo_q[DATA_W-1:1]};
                        end
                    end
                    ST_FIX:  result_q <= add_sum[DATA_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    assign busy      = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign done      = (state_q == ST_DONE);
    assign stall_req = busy | ((state_q == ST_IDLE) & start & ~flush);
    assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit against an arithmetic reference
module tb_muldiv_unit;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk;
    logic        arst_n;
    logic        enable;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [63:0] operand_a;
    logic [63:0] operand_b;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] prev_res = '0;

    muldiv_unit #(.DATA_W(64)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .enable    (enable),
        .start     (start),
        .flush     (flush),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_muldiv(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
        logic [127:0]       xa, xb, p;
        logic signed [63:0] sa, sb;
        sa = a;
        sb = b;
        xa = (f == MULH || f == MULHSU) ? {{64{a[63]}}, a} : {64'd0, a};
        xb = (f == MULH) ? {{64{b[63]}}, b} : {64'd0, b};
        p  = xa * xb;
        case (f)
            MUL:                  return p[63:0];
            MULH, MULHSU, MULHU:  return p[127:64];
            DIV:  return (b == 0) ? ONES : (a == MINV && b == ONES) ? MINV : 64'(sa / sb);
            REM:  return (b == 0) ? a    : (a == MINV && b == ONES) ? 64'd0 : 64'(sa % sb);
            DIVU: return (b == 0) ? ONES : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Cycle 0 is the cycle start is presented; expectations follow the unit's timing rules
    task automatic do_op(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                         input int flush_c, input int dis_c, input int dis_n, input int rst_c,
                         input logic use_lit, input logic [63:0] lit);
        logic        special;
        int          d, last, dn;
        logic [63:0] exp_res, res_e;
        logic        busy_e, done_e, stall_e;
        special = f[2] && (b == 0 || (!f[0] && a == MINV && b == ONES));
        dn      = special ? 0 : dis_n;
        d       = special ? 1 : 66 + dn;
        last    = d + 1;
        if (flush_c >= 0) last = flush_c + 1;
        if (rst_c >= 0) last = rst_c + 1;
        exp_res = ref_muldiv(f, a, b);
        if (use_lit) chk("model_lit", exp_res, lit);
        for (int c = 0; c <= last; c++) begin
            @(posedge clk);
            #1;
            start  = (c == 0);
            enable = !(dn > 0 && c >= dis_c && c < dis_c + dn);
            flush  = (c == flush_c);
            arst_n = (c != rst_c);
            if (c == 0) begin
                op        = f;
                operand_a = a;
                operand_b = b;
            end else begin
                op        = 3'($urandom);
                operand_a = {$urandom, $urandom};
                operand_b = {$urandom, $urandom};
            end
            @(negedge clk);
            if ((flush_c >= 0 && c > flush_c) || (rst_c >= 0 && c > rst_c)) begin
                busy_e = 1'b0;
                done_e = 1'b0;
                stall_e = 1'b0;
            end else begin
                busy_e  = !special && c >= 1 && c < d;
                done_e  = (c == d);
                stall_e = (c == 0) || busy_e;
            end
            if (rst_c >= 0 && c > rst_c) res_e = '0;
            else if (flush_c < 0 && c >= d) res_e = exp_res;
            else res_e = prev_res;
            chk("stall_req", 64'(stall_req), 64'(stall_e));
            chk("busy", 64'(busy), 64'(busy_e));
            chk("done", 64'(done), 64'(done_e));
            chk("result", result, res_e);
            if (done_e && use_lit) chk("result_lit", result, lit);
        end
        prev_res = res_e;
        start = 1'b0;
        flush = 1'b0;
        enable = 1'b1;
        arst_n = 1'b1;
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return ONES;
            2: return MINV;
            3: return 64'($urandom_range(0, 20));
            4: return -64'($urandom_range(1, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [2:0]  rf;
        logic [63:0] ra, rb;
        int          rdc, rdn;
        arst_n = 1'b0;
        enable = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op = '0;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 64'(stall_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", result, 64'd0);
        arst_n = 1'b1;

        do_op(MUL,    64'd7, -64'd3, -1, 0, 0, -1, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
        do_op(MULHU,  ONES, ONES,    -1, 0, 0, -1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        do_op(MULH,   ONES, ONES,    -1, 0, 0, -1, 1'b1, 64'd0);
        do_op(MULHSU, ONES, 64'd2,   -1, 0, 0, -1, 1'b1, ONES);
        do_op(DIV,   -64'd7, 64'd2,  -1, 0, 0, -1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(REM,   -64'd7, 64'd2,  -1, 0, 0, -1, 1'b1, ONES);
        do_op(DIVU,   64'd7, 64'd2,  -1, 0, 0, -1, 1'b1, 64'd3);
        do_op(REMU,   64'd7, 64'd2,  -1, 0, 0, -1, 1'b1, 64'd1);
        do_op(DIV,    64'd5, 64'd0,  -1, 0, 0, -1, 1'b1, ONES);
        do_op(DIV,    MINV, ONES,    -1, 0, 0, -1, 1'b1, MINV);
        do_op(REM,    MINV, ONES,    -1, 0, 0, -1, 1'b1, 64'd0);
        do_op(REM,    64'd5, 64'd0,  -1, 0, 0, -1, 1'b1, 64'd5);
        do_op(DIV,    64'd100, 64'd7, 10, 0, 0, -1, 1'b0, 64'd0);
        do_op(MUL,    64'd3, 64'd5,  -1, 0, 0, -1, 1'b1, 64'd15);
        do_op(MUL,    64'h1_2345_6789, 64'h1000, -1, 20, 5, -1, 1'b1, 64'h1234_5678_9000);
        do_op(MUL,    64'd11, 64'd13, -1, 0, 0, 30, 1'b0, 64'd0);

        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            rdn = 0;
            rdc = 0;
            if ($urandom_range(0, 3) == 0) begin
                rdc = $urandom_range(1, 60);
                rdn = $urandom_range(1, 4);
            end
            do_op(rf, ra, rb, -1, rdc, rdn, -1, 1'b0, 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit implementing the RV64M integer operations for the EX stage of the pipelined core. It is parametrised in datapath width and uses one radix-2 iteration per cycle. It raises a stall request that holds the front of the pipeline while the operation is in progress. Division-by-zero and signed-overflow cases complete early.

## Interface
Parameters:
- DATA_W, 64, operand/result width; even, ≥8
- CNT_W, $clog2(DATA_W)+1, iteration counter width (derived, not overridden)

Ports:
- clk  in  1  clock, all state updates on rising edge
- arst_n  in  1  reset; synchronous, active-low
- enable  in  1  global run enable; 0 freezes all state (same as core pipeline registers)
- start  in  1  EX holds an M-type instruction; sampled only in IDLE
- flush  in  1  squash current operation (branch/jump taken)
- op  in  3  func3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- operand_a  in  DATA_W  rs1 value (after forwarding)
- operand_b  in  DATA_W  rs2 value (after forwarding)
- stall_req  out  1  hold PC, IF/ID, ID/EX
- busy  out  1  state is CALC or FIX
- done  out  1  result valid this cycle
- result  out  DATA_W  registered result

## Operation
- States: IDLE, CALC, FIX, DONE. Reset: IDLE, counter 0, result 0, done 0, busy 0, stall_req 0.
- IDLE, start=1, flush=0, normal case → CALC. Latch |a|, |b| per signedness; latch op and result sign flags; counter=0.
  - Signed operands: MULH a,b; MULHSU a only; DIV/REM both.
- IDLE, start=1, special case → DONE directly; result written at the same edge.
  - b=0: DIV/DIVU result all-ones; REM/REMU result = a.
  - Signed DIV with a=MIN, b=-1: result MIN. Signed REM with same operands: result 0.
- CALC, one iteration per edge; counter increments; after DATA_W iterations → FIX.
  - Multiply: shift-add into a 2·DATA_W product.
  - Divide: restoring shift-subtract on a DATA_W+1 bit partial remainder.
- FIX → DONE.
  - Negate the product if exactly one signed operand is negative.
  - Quotient negated if the operand signs differ; remainder takes the sign of the dividend.
  - Select the half: low for MUL, high for MULH*.
  - result is written at this edge.
- DONE → IDLE unconditionally. done=1 for exactly one enabled cycle. start is ignored in DONE.
- stall_req = busy | (state==IDLE & start & ~flush). This is combinational from start/flush; it is 0 in DONE so the instruction leaves EX at that edge.
- flush=1 in any state → IDLE at the next enabled edge.
  - Priority: flush over start.
  - done is not raised and result is unchanged.
- enable=0: state, counter, datapath and result hold. Outputs keep their current values.
- arst_n=0 at any edge, mid-operation included, → reset values. No partial result is retained.

## Timing
- Start sampled in cycle 0. Normal case: done in cycle DATA_W+2, which is 66 for DATA_W=64.
- stall_req is high in cycles 0..DATA_W+1.
- Special case: done in cycle 1; stall_req high in cycle 0 only.
- Each enable=0 cycle during an operation delays done by exactly one cycle.
- A back-to-back start is accepted at the earliest in cycle DATA_W+3, in IDLE.

## Structure
- Package muldiv_pkg holds:
  - the state enum;
  - the func3 op localparams;
  - helper functions is_signed_a, is_signed_b, is_div.
- No sub-module. A single shared DATA_W+1 adder/subtractor serves both the iteration and the FIX negation, kept inline.

## Test plan
All with DATA_W=64.
- MUL a=7, b=-3 → result 0xFFFFFFFFFFFFFFEB; done in cycle 66; stall_req high in cycles 0–65.
- MULHU a=b=0xFFFFFFFFFFFFFFFF → 0xFFFFFFFFFFFFFFFE. MULH with the same operands → 0. MULHSU a=-1, b=2 → 0xFFFFFFFFFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFFFFFFFFFD. REM -7/2 → 0xFFFFFFFFFFFFFFFF. DIVU 7/2 → 3. REMU 7/2 → 1.
- Early completion, each with done in cycle 1:
  - DIV 5/0 → all-ones; REM 5/0 → 5.
  - DIV 0x8000000000000000/-1 → 0x8000000000000000; REM with the same operands → 0.
- flush in cycle 10 of a DIV:
  - IDLE in cycle 11; done never raised; result keeps its previous value.
  - A new start in cycle 12 completes in cycle 78.
- Mid-operation disturbances:
  - enable low for cycles 20–24 of a MUL → done in cycle 71.
  - arst_n low in cycle 30 of a MUL → IDLE, result 0, stall_req 0 in the next cycle.
